rgb_fpga_fb_sched: RTL

Frame-buffer scheduler between a single-port pixel RAM and the six per-colour line PWM units (r0/g0/b0/r1/g1/b1).
- Fetches one matrix row of pixel pairs into a shadow register on request, then commits it to the line units at line start.
- Arbitrates RAM access between display fetch (priority) and host pixel writes.
- Double-buffers frames, with the bank swap applied at the frame boundary.

---
 rtl/rgb_fpga_pkg.sv | 34 +++
 rtl/rgb_fpga_gamma_lut.sv | 22 ++
 rtl/rgb_fpga_fb_sched.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/rgb_fpga_pkg.sv
// Shared constants, pixel/line types and scheduler state encoding for the RGB frame-buffer scheduler.
package rgb_fpga_pkg;

    localparam int COLS   = 32;
    localparam int ROWS   = 16;
    localparam int DEPTH  = 8;
    localparam int ROW_W  = 4;
    localparam int COL_W  = 5;
    localparam int NCH    = 6;
    localparam int WORD_W = NCH * DEPTH;
    localparam int ADDR_W = 1 + ROW_W + COL_W;

    typedef struct packed {
        logic [DEPTH-1:0] r0;
        logic [DEPTH-1:0] g0;
        logic [DEPTH-1:0] b0;
        logic [DEPTH-1:0] r1;
        logic [DEPTH-1:0] g1;
        logic [DEPTH-1:0] b1;
    } pixel_pair_t;

    typedef logic [COLS-1:0][DEPTH-1:0] line_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } fb_state_t;

    function automatic logic [COL_W-1:0] col_of(input logic [ADDR_W-1:0] addr);
        return addr[COL_W-1:0];
    endfunction

endpackage

// File: rtl/rgb_fpga_gamma_lut.sv
// One-cycle registered gamma mapping (gamma 2.0, round half up) for a single colour channel.
module rgb_fpga_gamma_lut
    import rgb_fpga_pkg::*;
(
    input  logic             clk,
    input  logic [DEPTH-1:0] din,
    output logic [DEPTH-1:0] dout
);

    // Square then keep the upper half; the rounding offset cannot overflow the 2*DEPTH product.
    function automatic logic [DEPTH-1:0] gamma_round(input logic [DEPTH-1:0] x);
        logic [2*DEPTH-1:0] sq;
        sq = {{DEPTH{1'b0}}, x} * {{DEPTH{1'b0}}, x};
        sq = sq + (2*DEPTH)'(1 << (DEPTH-1));
        return sq[2*DEPTH-1:DEPTH];
    endfunction

    always_ff @(posedge clk) begin
        dout <= gamma_round(din);
    end

endmodule

// File: rtl/rgb_fpga_fb_sched.sv
// Frame-buffer scheduler: row fetch into a shadow line, host write arbitration and bank swap.
// Optional RGB_FB_GAMMA_EN inserts a registered gamma LUT stage between RAM read data and the shadow.
module rgb_fpga_fb_sched
    import rgb_fpga_pkg::*;
(
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              enable,
    input  logic                              fetch_req,
    input  logic [ROW_W-1:0]                  fetch_row,
    output logic                              fetch_done,
    input  logic                              line_start,
    input  logic                              frame_rdy,
    output logic [5:0][COLS-1:0][DEPTH-1:0]   line_data,
    input  logic                              host_we,
    input  logic [ROW_W+COL_W-1:0]            host_addr,
    input  logic [WORD_W-1:0]                 host_wdata,
    output logic                              host_ack,
    input  logic                              host_swap,
    output logic                              swap_pend,
    output logic                              underrun,
    output logic [ADDR_W-1:0]                 ram_addr,
    output logic                              ram_we,
    output logic [WORD_W-1:0]                 ram_wdata,
    input  logic [WORD_W-1:0]                 ram_rdata
);

    fb_state_t state, state_nxt;

    logic display_bank;
    logic shadow_valid;
    logic fetch_go, host_go, abort, last_issue, cap_last, done_nxt;

    logic             vld_p0;
    logic [COL_W-1:0] col_p0;

    logic             cap_vld;
    logic [COL_W-1:0] cap_col;
    pixel_pair_t      cap_px;

    logic [5:0][COLS-1:0][DEPTH-1:0] shadow;

    assign fetch_go   = enable & fetch_req & (state == IDLE);
    assign host_go    = host_we & (state == IDLE) & ~fetch_go & ~host_ack;
    assign abort      = ~enable & (state != IDLE);
    assign last_issue = (state == FETCH) & (col_of(ram_addr) == COL_W'(COLS-1));
    assign cap_last   = cap_vld & (cap_col == COL_W'(COLS-1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (fetch_go) state_nxt = FETCH;
            end
            FETCH: begin
                if (!enable)         state_nxt = IDLE;
                else if (last_issue) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (!enable) begin
                    state_nxt = IDLE;
                end else if (cap_last) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // p0: read data for the column addressed last cycle is on ram_rdata
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p0 <= 1'b0;
        end else begin
            vld_p0 <= (state == FETCH) & enable;
        end
    end

    always_ff @(posedge clk) begin
        col_p0 <= col_of(ram_addr);
    end

`ifdef RGB_FB_GAMMA_EN
    // p1: gamma-mapped read data
    logic              vld_p1;
    logic [COL_W-1:0]  col_p1;
    logic [WORD_W-1:0] gamma_p1;

    for (genvar c = 0; c < NCH; c++) begin : g_lut
        rgb_fpga_gamma_lut u_lut (
            .clk  (clk),
            .din  (ram_rdata[c*DEPTH +: DEPTH]),
            .dout (gamma_p1[c*DEPTH +: DEPTH])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= vld_p0 & enable;
        end
    end

    always_ff @(posedge clk) begin
        col_p1 <= col_p0;
    end

    assign cap_vld = vld_p1;
    assign cap_col = col_p1;
    assign cap_px  = gamma_p1;
`else
    assign cap_vld = vld_p0;
    assign cap_col = col_p0;
    assign cap_px  = ram_rdata;
`endif

    always_ff @(posedge clk) begin
        if (cap_vld) begin
            shadow[0][cap_col] <= cap_px.r0;
            shadow[1][cap_col] <= cap_px.g0;
            shadow[2][cap_col] <= cap_px.b0;
            shadow[3][cap_col] <= cap_px.r1;
            shadow[4][cap_col] <= cap_px.g1;
            shadow[5][cap_col] <= cap_px.b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            display_bank <= 1'b0;
            swap_pend    <= 1'b0;
            shadow_valid <= 1'b0;
            underrun     <= 1'b0;
            fetch_done   <= 1'b0;
            host_ack     <= 1'b0;
            ram_we       <= 1'b0;
            ram_addr     <= '0;
            ram_wdata    <= '0;
            line_data    <= '0;
        end else begin
            fetch_done <= done_nxt;
            host_ack   <= host_go;
            ram_we     <= host_go;

            // The bank bit is latched into ram_addr at fetch start; only the column advances.
            if (fetch_go) begin
                ram_addr <= {display_bank, fetch_row, COL_W'(0)};
            end else if ((state == FETCH) & enable & ~last_issue) begin
                ram_addr[COL_W-1:0] <= col_of(ram_addr) + COL_W'(1);
            end else if (host_go) begin
                ram_addr  <= {~display_bank, host_addr};
                ram_wdata <= host_wdata;
            end

            if (frame_rdy & (swap_pend | host_swap)) begin
                display_bank <= ~display_bank;
                swap_pend    <= 1'b0;
            end else if (host_swap) begin
                swap_pend <= 1'b1;
            end

            if (line_start) begin
                if (shadow_valid) line_data <= shadow;
                else              underrun  <= 1'b1;
            end

            // A starting fetch overwrites the shadow, so an uncommitted row is no longer valid.
            if (done_nxt) begin
                shadow_valid <= 1'b1;
            end else if (fetch_go | abort | (line_start & shadow_valid)) begin
                shadow_valid <= 1'b0;
            end
        end
    end

endmodule
